fc_argmax: RTL and testbench

FC_ARGMAX -- requirements
Module: fc_argmax

---
 rtl/fc_pkg.sv | 21 ++
 rtl/sat_add.sv | 30 +++
 rtl/fc_argmax.sv | 124 ++++++++++++
 tb/tb_fc_argmax.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// fc_pkg : shared constants for the FC-layer argmax block
// Rev 1.0 : initial release
// ============================================================================
package fc_pkg;

    localparam int WORD_SIZE = 16;
    localparam int NUM_CLASS = 4;
    localparam int IDX_W     = $clog2(NUM_CLASS);

    // Saturation bounds of a (WORD_SIZE+1)-bit signed word
    localparam int SAT_MAX   = (1 << WORD_SIZE) - 1;
    localparam int SAT_MIN   = -(1 << WORD_SIZE);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sat_add.sv
`default_nettype none
// ============================================================================
// sat_add : combinational signed adder clamped to the WIDTH-bit signed range
// Rev 1.0 : initial release
// ============================================================================
module sat_add
    import fc_pkg::*;
#(
    parameter int WIDTH = WORD_SIZE + 1
) (
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic signed [WIDTH-1:0] o_sum
);

    logic signed [WIDTH:0] w_full;

    assign w_full = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};

    // Overflow whenever the two top bits of the widened sum disagree
    always_comb begin
        o_sum = w_full[WIDTH-1:0];
        if (w_full[WIDTH] != w_full[WIDTH-1]) begin
            o_sum = w_full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fc_argmax.sv
`default_nettype none
// ============================================================================
// fc_argmax : biases four FC-layer scores and serially picks the largest
// Rev 1.0 : initial release
// ============================================================================
module fc_argmax
    import fc_pkg::*;
#(
    parameter int word_size = WORD_SIZE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_valid,
    input  logic signed [word_size:0]   i_result_0,
    input  logic signed [word_size:0]   i_result_1,
    input  logic signed [word_size:0]   i_result_2,
    input  logic signed [word_size:0]   i_result_3,
    input  logic signed [word_size:0]   i_bias_0,
    input  logic signed [word_size:0]   i_bias_1,
    input  logic signed [word_size:0]   i_bias_2,
    input  logic signed [word_size:0]   i_bias_3,
    input  logic                        i_ready,
    output logic [1:0]                  o_class,
    output logic signed [word_size:0]   o_score,
    output logic                        o_valid,
    output logic                        o_busy,
    output logic                        o_drop
);

    localparam int              DW       = word_size + 1;
    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(NUM_CLASS - 1);

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic signed [DW-1:0]    w_res  [NUM_CLASS];
    logic signed [DW-1:0]    w_bias [NUM_CLASS];
    logic signed [DW-1:0]    w_sum  [NUM_CLASS];
    logic signed [DW-1:0]    r_sum  [NUM_CLASS];
    logic signed [DW-1:0]    r_best;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        r_cnt;
    logic                    r_drop;

    assign w_res[0]  = i_result_0;
    assign w_res[1]  = i_result_1;
    assign w_res[2]  = i_result_2;
    assign w_res[3]  = i_result_3;
    assign w_bias[0] = i_bias_0;
    assign w_bias[1] = i_bias_1;
    assign w_bias[2] = i_bias_2;
    assign w_bias[3] = i_bias_3;

    for (genvar k = 0; k < NUM_CLASS; k++) begin : g_sat
        sat_add #(.WIDTH(DW)) u_sat_add (
            .i_a   (w_res[k]),
            .i_b   (w_bias[k]),
            .o_sum (w_sum[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_valid)             w_state_nxt = ST_SCAN;
            ST_SCAN: if (r_cnt == CNT_LAST)   w_state_nxt = ST_DONE;
            ST_DONE: if (i_ready)             w_state_nxt = ST_IDLE;
            default:                          w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (r_state != ST_IDLE);
        o_valid = (r_state == ST_DONE);
    end

    // Class 0 seeds the running best; strict compare keeps the lowest index on ties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CLASS; k++) begin
                r_sum[k] <= '0;
            end
            r_best <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_drop <= 1'b0;
        end else begin
            r_drop <= i_valid && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        for (int k = 0; k < NUM_CLASS; k++) begin
                            r_sum[k] <= w_sum[k];
                        end
                        r_best <= w_sum[0];
                        r_idx  <= '0;
                        r_cnt  <= IDX_W'(1);
                    end
                end
                ST_SCAN: begin
                    if (r_sum[r_cnt] > r_best) begin
                        r_best <= r_sum[r_cnt];
                        r_idx  <= r_cnt;
                    end
                    r_cnt <= r_cnt + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_class = r_idx;
    assign o_score = r_best;
    assign o_drop  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_fc_argmax.sv
`default_nettype none
// ============================================================================
// tb_fc_argmax : directed scenarios plus random frames against an argmax model
// Rev 1.0 : initial release
// ============================================================================
module tb_fc_argmax;
    import fc_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               i_valid;
    logic               i_ready;
    logic signed [16:0] p_res  [4];
    logic signed [16:0] p_bias [4];
    logic [1:0]         o_class;
    logic signed [16:0] o_score;
    logic               o_valid;
    logic               o_busy;
    logic               o_drop;

    int tb_res  [4];
    int tb_bias [4];
    int n_checks;
    int n_fail;
    int n_drop;
    int n_hs;

    fc_argmax #(.word_size(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_result_0 (p_res[0]),
        .i_result_1 (p_res[1]),
        .i_result_2 (p_res[2]),
        .i_result_3 (p_res[3]),
        .i_bias_0   (p_bias[0]),
        .i_bias_1   (p_bias[1]),
        .i_bias_2   (p_bias[2]),
        .i_bias_3   (p_bias[3]),
        .i_ready    (i_ready),
        .o_class    (o_class),
        .o_score    (o_score),
        .o_valid    (o_valid),
        .o_busy     (o_busy),
        .o_drop     (o_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_drop) n_drop++;
        if (o_valid && i_ready) n_hs++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction

    // Winner = maximum biased score; among equal maxima the smallest index
    task automatic ref_argmax(output int cls, output int scr);
        int s [4];
        int m;
        foreach (s[k]) s[k] = clamp(tb_res[k] + tb_bias[k]);
        m = s[0];
        foreach (s[k]) m = (s[k] > m) ? s[k] : m;
        cls = 0;
        for (int k = 3; k >= 0; k--) if (s[k] == m) cls = k;
        scr = m;
    endtask

    task automatic set_vec(input int r0, r1, r2, r3, b0, b1, b2, b3);
        tb_res  = '{r0, r1, r2, r3};
        tb_bias = '{b0, b1, b2, b3};
    endtask

    task automatic apply_vec();
        for (int k = 0; k < 4; k++) begin
            p_res[k]  = 17'(tb_res[k]);
            p_bias[k] = 17'(tb_bias[k]);
        end
    endtask

    function automatic int rnd17();
        return int'($urandom_range(0, 131071)) - 65536;
    endfunction

    // One frame: launch, check latency, hold for 'hold' cycles (optionally with a
    // second i_valid to be dropped), release and check the return to IDLE.
    task automatic run_frame(input int hold, input bit inject);
        int ec, es;
        ref_argmax(ec, es);
        @(negedge clk);
        apply_vec();
        i_valid = 1'b1;
        i_ready = (hold == 0);
        @(negedge clk);
        i_valid = 1'b0;
        chk("busy_scan", int'(o_busy), 1);
        chk("valid_early", int'(o_valid), 0);
        repeat (2) begin
            @(negedge clk);
            chk("valid_early", int'(o_valid), 0);
        end
        @(negedge clk);
        chk("valid_lat", int'(o_valid), 1);
        chk("class", int'(o_class), ec);
        chk("score", int'(o_score), es);
        chk("no_drop", int'(o_drop), 0);
        for (int c = 0; c < hold; c++) begin
            if (inject && c == 2) begin
                for (int k = 0; k < 4; k++) p_res[k] = 17'(rnd17());
                i_valid = 1'b1;
            end
            @(negedge clk);
            if (inject && c == 2) begin
                i_valid = 1'b0;
                chk("drop_pulse", int'(o_drop), 1);
            end else begin
                chk("drop_quiet", int'(o_drop), 0);
            end
            chk("hold_valid", int'(o_valid), 1);
            chk("hold_class", int'(o_class), ec);
            chk("hold_score", int'(o_score), es);
        end
        i_ready = 1'b1;
        @(negedge clk);
        chk("released_valid", int'(o_valid), 0);
        chk("released_busy", int'(o_busy), 0);
        i_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, int'(o_valid), 0);
        chk({tag, "_busy"},  int'(o_busy), 0);
        chk({tag, "_drop"},  int'(o_drop), 0);
        chk({tag, "_class"}, int'(o_class), 0);
        chk({tag, "_score"}, int'(o_score), 0);
    endtask

    initial begin
        int mode;
        n_checks = 0;
        n_fail   = 0;
        n_drop   = 0;
        n_hs     = 0;
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        set_vec(0, 0, 0, 0, 0, 0, 0, 0);
        apply_vec();
        #1;
        chk_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic, tie with bias, and both saturation directions
        set_vec(10, 50, 20, -5, 0, 0, 0, 0);
        run_frame(0, 1'b0);
        set_vec(100, 100, 90, 100, 0, 0, 10, 0);
        run_frame(0, 1'b0);
        set_vec(0, 0, 0, 65000, 0, 0, 0, 2000);
        run_frame(0, 1'b0);
        set_vec(-65000, -65536, -65536, -65536, -2000, -4464, -4464, -4464);
        run_frame(0, 1'b0);

        // Backpressure with a dropped second i_valid
        set_vec(7, -3, 300, 299, 0, 0, 0, 0);
        n_drop = 0;
        run_frame(10, 1'b1);
        chk("drop_count", n_drop, 1);

        // Reset in the middle of a scan
        set_vec(1, 2, 3, 4, 0, 0, 0, 0);
        @(negedge clk);
        apply_vec();
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk_reset_outputs("midscan_rst");
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_valid", int'(o_valid), 0);
        end
        rst_n = 1'b1;
        set_vec(-40, 12, 12, -7, 5, 0, 0, 0);
        run_frame(0, 1'b0);

        // Back-to-back frames at a 102-cycle period
        n_drop = 0;
        n_hs   = 0;
        for (int f = 0; f < 5; f++) begin
            set_vec(rnd17(), rnd17(), rnd17(), rnd17(), 0, 0, 0, 0);
            run_frame(0, 1'b0);
            repeat (96) @(negedge clk);
        end
        chk("b2b_drops", n_drop, 0);
        chk("b2b_results", n_hs, 5);

        // Random frames: full range, forced ties, near-saturation
        for (int f = 0; f < 24; f++) begin
            mode = int'($urandom_range(0, 2));
            for (int k = 0; k < 4; k++) begin
                case (mode)
                    0: begin
                        tb_res[k]  = rnd17();
                        tb_bias[k] = int'($urandom_range(0, 200)) - 100;
                    end
                    1: begin
                        tb_res[k]  = 10 * int'($urandom_range(0, 2));
                        tb_bias[k] = 0;
                    end
                    default: begin
                        tb_res[k]  = ($urandom_range(0, 1) != 0) ? 65535 - int'($urandom_range(0, 2000))
                                                                 : -65536 + int'($urandom_range(0, 2000));
                        tb_bias[k] = rnd17();
                    end
                endcase
            end
            begin
                int h;
                h = int'($urandom_range(0, 4));
                run_frame(h, (h >= 3) && ($urandom_range(0, 1) != 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
